// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider, 32 iterations, result {rem, quo}.
// Define DIV_SIGNED_EN to honour signed_div_i (DIV); otherwise DIVU only.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      S_FREE,
      S_BY_ZERO,
      S_ON,
      S_END
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic [32:0] shifted;
   logic [33:0] trial;
   logic [31:0] op1_mag, op2_mag;
   logic [31:0] quo_fix, rem_fix;
   logic        accept;

   assign accept = (state_q == S_FREE) && start_i && !annul_i;

`ifdef DIV_SIGNED_EN
   logic neg1, neg2;
   logic negq_q, negq_d, negr_q, negr_d;

   assign neg1    = signed_div_i & opdata1_i[31];
   assign neg2    = signed_div_i & opdata2_i[31];
   assign op1_mag = neg1 ? -opdata1_i : opdata1_i;
   assign op2_mag = neg2 ? -opdata2_i : opdata2_i;
   assign quo_fix = negq_q ? -dvd_q : dvd_q;
   assign rem_fix = negr_q ? -rem_q : rem_q;

   // Remainder follows the dividend sign; quotient flips on sign mismatch.
   always_comb begin
      negq_d = negq_q;
      negr_d = negr_q;
      if (accept) begin
         negq_d = neg1 ^ neg2;
         negr_d = neg1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end
`else
   logic unused_sign;

   assign unused_sign = signed_div_i;
   assign op1_mag     = opdata1_i;
   assign op2_mag     = opdata2_i;
   assign quo_fix     = dvd_q;
   assign rem_fix     = rem_q;
`endif

   // Quotient bits shift into the dividend register as it empties.
   assign shifted = {rem_q, dvd_q[31]};
   assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      result_d = result_q;
      ready_d  = ready_q;
      unique case (state_q)
         S_FREE: begin
            if (accept) begin
               dvd_d = op1_mag;
               dvs_d = op2_mag;
               rem_d = '0;
               cnt_d = '0;
               if (opdata2_i == '0) begin
                  state_d = S_BY_ZERO;
               end else begin
                  state_d = S_ON;
               end
            end
         end
         S_BY_ZERO: begin
            state_d  = S_END;
            result_d = '0;
            ready_d  = 1'b1;
         end
         S_ON: begin
            if (annul_i) begin
               state_d = S_FREE;
               cnt_d   = '0;
            end else if (cnt_q < 6'd32) begin
               if (!trial[33]) begin
                  rem_d = trial[31:0];
                  dvd_d = {dvd_q[30:0], 1'b1};
               end else begin
                  rem_d = shifted[31:0];
                  dvd_d = {dvd_q[30:0], 1'b0};
               end
               cnt_d = cnt_q + 6'd1;
            end else begin
               state_d  = S_END;
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
            end
         end
         S_END: begin
            if (!start_i || annul_i) begin
               state_d  = S_FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_FREE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: random and directed divides vs a
// plain-arithmetic model; monitor compares whenever ready_o rises.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] cur_exp = '0;
   logic        rdy_prev = 1'b0;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic s);
      logic        eff;
      longint      sa, sb;
      logic [31:0] q, r;
`ifdef DIV_SIGNED_EN
      eff = s;
`else
      eff = s & 1'b0;
`endif
      if (b == 32'd0) return 64'd0;
      if (eff) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Monitor: pop on each rising ready_o, then demand stability while high.
   always @(negedge clk) begin
      if (!rst) begin
         rdy_prev = 1'b0;
      end else begin
         if (ready_o && !rdy_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: got %h expected none",
                        result_o);
            end else begin
               cur_exp = exp_q.pop_front();
               check("result", result_o, cur_exp);
            end
         end else if (ready_o) begin
            check("hold_result", result_o, cur_exp);
         end
         rdy_prev = ready_o;
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int hold,
                         input bit rst_end, output logic [63:0] res);
      int n;
      int lat;
      @(negedge clk);
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = s;
      annul_i      = 1'b0;
      start_i      = 1'b1;
      exp_q.push_back(model(a, b, s));
      lat = (b == 32'd0) ? 2 : 34;
      n   = 0;
      while (!ready_o && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (!ready_o) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
         end
      end
      res = result_o;
      if (!ready_o) begin
         check("ready_timeout", {63'd0, ready_o}, 64'd1);
         exp_q.delete();
         start_i = 1'b0;
         return;
      end
      check("latency", 64'(n), 64'(lat));
      repeat (hold) begin
         opdata1_i    = $urandom;
         opdata2_i    = $urandom;
         signed_div_i = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      check("hold_ready", {63'd0, ready_o}, 64'd1);
      if (rst_end) begin
         #2 rst = 1'b0;
         #1;
         check("rst_end_ready", {63'd0, ready_o}, 64'd0);
         check("rst_end_result", result_o, 64'd0);
         start_i = 1'b0;
         @(negedge clk);
         rst = 1'b1;
      end else begin
         start_i = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("drop_ready", {63'd0, ready_o}, 64'd0);
         check("drop_result", result_o, 64'd0);
      end
   endtask

   task automatic idle_no_ready(input string name, input int cycles);
      int hi;
      hi = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (ready_o) hi++;
      end
      check(name, 64'(hi), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] res;
      logic [31:0] a, b;
      int          sel;
      rst          = 1'b0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      #12;
      check("reset_ready", {63'd0, ready_o}, 64'd0);
      check("reset_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op(32'd100, 32'd7, 1'b0, 0, 1'b0, res);
      check("u100_7", res, 64'h00000002_0000000E);

`ifdef DIV_SIGNED_EN
      run_op(-32'sd7, 32'd2, 1'b1, 0, 1'b0, res);
      check("s_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0, res);
      check("s_min_m1", res, 64'h00000000_80000000);
`endif

      run_op(32'd5, 32'd0, 1'b0, 0, 1'b0, res);
      check("div_zero", res, 64'd0);

      // Annul sampled on edge 10, start dropped right after.
      @(negedge clk);
      opdata1_i = 32'hFFFFFFFF;
      opdata2_i = 32'd3;
      start_i   = 1'b1;
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      annul_i = 1'b0;
      idle_no_ready("annul_no_ready", 40);
      run_op(32'd9, 32'd3, 1'b0, 0, 1'b0, res);
      check("after_annul", res, 64'h00000000_00000003);

      // Asynchronous reset in the middle of the iterations.
      @(negedge clk);
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i   = 1'b1;
      exp_q.push_back(model(32'd100, 32'd7, 1'b0));
      repeat (15) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_on_ready", {63'd0, ready_o}, 64'd0);
      check("rst_on_result", result_o, 64'd0);
      exp_q.delete();
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle_no_ready("rst_no_ready", 40);
      run_op(32'd100, 32'd7, 1'b0, 0, 1'b0, res);
      check("after_rst", res, 64'h00000002_0000000E);

      run_op(32'd1000, 32'd33, 1'b0, 5, 1'b0, res);
      check("hold_5", res, {32'd10, 32'd30});

      run_op(32'd77, 32'd5, 1'b0, 2, 1'b1, res);
      idle_no_ready("rst_end_idle", 5);

      for (int i = 0; i < 40; i++) begin
         a   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'd0;
         else if (sel < 4) b = 32'($urandom_range(1, 15));
         else if (sel == 4) begin
            a = 32'h80000000;
            b = 32'hFFFFFFFF;
         end else b = $urandom;
         run_op(a, b, 1'($urandom), $urandom_range(0, 3), 1'b0, res);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the execute stage. It performs DIV/DIVU for the HI/LO path using one radix-2 restoring step per cycle, 32 iterations in total. While the operation is in flight, the execute stage holds `stallreq_from_ex` high. That signal freezes PC, IF, ID and EX through the stall controller, and the execute stage releases it when `ready_o` asserts.

## Interface
Parameters:
- none; operand width is fixed at 32 bits and the iteration count at 32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets immediately, independent of `clk`).
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- `opdata1_i`  in  32  dividend; sampled at start.
- `opdata2_i`  in  32  divisor; sampled at start.
- `start_i`  in  1  request; held high by EX until `ready_o` is seen, then dropped.
- `annul_i`  in  1  abort the in-flight operation (flush/exception).
- `result_o`  out  64  {remainder, quotient}; [63:32] goes to HI, [31:0] to LO.
- `ready_o`  out  1  result valid.

## Operation
State machine with four states: FREE, BY_ZERO, ON, END. The reset state is FREE.

- **Reset:** state=FREE, `ready_o`=0, `result_o`=0, counter=0.
- **FREE:**
  - If `start_i`=1 and `annul_i`=0: latch operands and mode.
  - Divisor==0 -> BY_ZERO. Otherwise -> ON with counter=0.
  - If `start_i`=0 or `annul_i`=1: stay in FREE.
- **BY_ZERO:** next edge -> END with quotient=0 and remainder=0.
- **ON:**
  - While counter<32: one restoring step per edge.
    - Shift the partial remainder left, bringing in the next dividend bit MSB-first.
    - Compute a 33-bit trial subtract of the divisor.
    - Non-negative: keep the difference and set quotient bit=1. Otherwise: restore and set quotient bit=0.
    - Counter increments.
  - Edge with counter==32: apply sign fix-up, load `result_o`, go to END.
  - `annul_i`=1 on any edge -> FREE; partial result discarded, `ready_o` stays 0.
- **END:**
  - `ready_o`=1 and `result_o` hold while `start_i`=1.
  - Edge with `start_i`=0 -> FREE, `ready_o`=0, `result_o`=0.
  - `annul_i` in END behaves the same as `start_i`=0.
- **Signed arithmetic:**
  - A negative operand is converted to its magnitude (two's complement) at start.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (natural wrap, no trap).
- **Operand stability:** changes to `opdata*_i` and `signed_div_i` after the start edge have no effect.

## Timing
- Edge 1 is the edge that samples `start_i` in FREE.
- Nonzero divisor:
  - Edges 2..33 perform the 32 iterations.
  - Edge 34 enters END; `ready_o` is high from after edge 34.
- Zero divisor: `ready_o` is high after edge 2.
- `ready_o` and `result_o` are registered outputs; there is no combinational path from inputs.
- Back-to-back operations:
  - `start_i` must be low for at least one edge in END before the next request.
  - Earliest next start is sampled 1 edge after returning to FREE.
- Asynchronous `rst` assertion mid-operation returns all state to reset values at once. Release is synchronised by the system reset logic.

## Configuration
- `DIV_SIGNED_EN`:
  - Defined: `signed_div_i` is honoured (DIV and DIVU both supported).
  - Undefined:
    - `signed_div_i` is ignored; every operation is unsigned and the sign-conversion/fix-up logic is removed.
    - Latency is unchanged.

## Test plan
- **Unsigned:** `signed_div_i`=0, 100 / 7, hold `start_i` -> `ready_o` rises after edge 34; `result_o`=0x00000002_0000000E; drop `start_i` -> `ready_o`=0 and `result_o`=0 next edge.
- **Signed** (`DIV_SIGNED_EN` defined): -7 / 2 -> `result_o`=0xFFFFFFFF_FFFFFFFD. Then 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000.
- **Divide by zero:** 5 / 0 -> `ready_o` high after edge 2, `result_o`=0.
- **Annul:** start 0xFFFFFFFF / 3, assert `annul_i` at edge 10 -> state FREE, `ready_o` never rises. A new start 9 / 3 then yields 0x00000000_00000003 after a further 34 edges.
- **Async reset:** drive `rst`=0 mid-ON, between clock edges -> `ready_o`=0 and `result_o`=0 immediately. After release, a new 100 / 7 completes correctly.
- **Hold:** keep `start_i` high 5 extra cycles in END and change operands -> `result_o` stays stable, with no new operation started.
